// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command opcodes as {cs_n, ras_n, cas_n, we_n},
// error codes and init-sequence states, plus small decode helpers.
// Used by the init monitor and by the init/refresh controllers.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_EARLY  = 3'd1,
    ERR_ORDER  = 3'd2,
    ERR_TIMING = 3'd3,
    ERR_ADDR   = 3'd4,
    ERR_MODE   = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_PALL,
    S_REF,
    S_MRD,
    S_READY,
    S_ERROR
  } init_state_e;

  // Deselect (cs_n high) behaves exactly like NOP.
  function automatic logic is_nop(logic [3:0] cmd);
    return cmd[3] || (cmd == CMD_NOP);
  endfunction

  // Supported modes: CAS latency 2/3; burst length 1/2/4/8 or full page.
  function automatic logic mode_ok(logic [2:0] bl, logic [2:0] cl);
    return ((cl == 3'd2) || (cl == 3'd3)) && ((bl <= 3'd3) || (bl == 3'd7));
  endfunction

endpackage

// File: rtl/sdram_init_monitor_if.sv
// SDRAM command/address bus as seen at the device pins.
//   sdram_cmd  : {cs_n, ras_n, cas_n, we_n}
//   sdram_addr : A12..A0
// master = controller driving the pins, slave = monitor/device sampling them.
interface sdram_init_monitor_if;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;

  modport master (output sdram_cmd, output sdram_addr);
  modport slave  (input  sdram_cmd, input  sdram_addr);
endinterface

// File: rtl/sdram_gap_timer.sv
// Loadable down-counter measuring minimum command spacing.
//   load/load_val : start a gap of (load_val + 1) cycles
//   zero          : no gap pending; a non-NOP command is legal
module sdram_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_monitor.sv
// Device-side monitor for the SDRAM power-up sequence:
// T_POWERUP cycles of NOP, PALL (A10=1), >= REF_REQ auto-refreshes, MRS.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   sdram           : command/address bus (slave modport)
//   init_ok         : sequence completed legally (held until reset)
//   init_err        : sticky protocol error
//   err_code        : first error (0 none,1 EARLY,2 ORDER,3 TIMING,4 ADDR,5 MODE)
//   ref_cnt         : AREFs seen during init, saturating at 15
//   mode_bl/bt/cl   : mode register fields latched from the MRS address
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int unsigned T_POWERUP = 10000,
  parameter int unsigned T_RP      = 1,
  parameter int unsigned T_RFC     = 4,
  parameter int unsigned T_MRD     = 2,
  parameter int unsigned REF_REQ   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_init_monitor_if.slave  sdram,
  output logic                 init_ok,
  output logic                 init_err,
  output logic [2:0]           err_code,
  output logic [3:0]           ref_cnt,
  output logic [2:0]           mode_bl,
  output logic                 mode_bt,
  output logic [2:0]           mode_cl
);

  if ((T_RP < 1) || (T_RP > 16) || (T_RFC < 1) || (T_RFC > 16) ||
      (T_MRD < 1) || (T_MRD > 16) || (T_POWERUP < 1) || (REF_REQ > 15)) begin : g_bad_param
    $error("sdram_init_monitor: timing parameters must be 1..16, REF_REQ <= 15");
  end

  localparam int unsigned PW = $clog2(T_POWERUP + 1);
  localparam logic [PW-1:0]    PWR_LAST   = PW'(T_POWERUP - 1);
  localparam logic [GAP_W-1:0] LD_RP      = GAP_W'(T_RP - 1);
  localparam logic [GAP_W-1:0] LD_RFC     = GAP_W'(T_RFC - 1);
  localparam logic [GAP_W-1:0] LD_MRD     = GAP_W'(T_MRD - 1);
  localparam logic [3:0]       REF_REQ_L  = 4'(REF_REQ);

  init_state_e     state, state_n;
  logic [PW-1:0]   pwr_cnt, pwr_cnt_n;
  err_code_e       err_q, err_n;
  logic [3:0]      ref_q, ref_n;
  logic [2:0]      bl_q, bl_n, cl_q, cl_n;
  logic            bt_q, bt_n;

  logic [3:0]       cmd;
  logic [12:0]      addr;
  logic             cmd_nop;
  logic             t_load, t_zero;
  logic [GAP_W-1:0] t_val;
  logic             unused_addr_bits;

  assign cmd              = sdram.sdram_cmd;
  assign addr             = sdram.sdram_addr;
  assign cmd_nop          = is_nop(cmd);
  assign unused_addr_bits = ^{addr[12:11], addr[9:7]};

  sdram_gap_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_PWRUP;
      pwr_cnt <= '0;
      err_q   <= ERR_NONE;
      ref_q   <= '0;
      bl_q    <= '0;
      bt_q    <= 1'b0;
      cl_q    <= '0;
    end else begin
      state   <= state_n;
      pwr_cnt <= pwr_cnt_n;
      err_q   <= err_n;
      ref_q   <= ref_n;
      bl_q    <= bl_n;
      bt_q    <= bt_n;
      cl_q    <= cl_n;
    end
  end

  // Every error path moves to S_ERROR, which never changes err_q again,
  // so err_code naturally keeps only the first violation.
  always_comb begin
    state_n   = state;
    pwr_cnt_n = pwr_cnt;
    err_n     = err_q;
    ref_n     = ref_q;
    bl_n      = bl_q;
    bt_n      = bt_q;
    cl_n      = cl_q;
    t_load    = 1'b0;
    t_val     = '0;

    case (state)
      S_PWRUP: begin
        if (!cmd_nop) begin
          state_n = S_ERROR;
          err_n   = ERR_EARLY;
        end else begin
          pwr_cnt_n = pwr_cnt + 1'b1;
          if (pwr_cnt == PWR_LAST) state_n = S_PALL;
        end
      end

      S_PALL: begin
        if (!cmd_nop) begin
          if (cmd == CMD_PALL && addr[10]) begin
            t_load  = 1'b1;
            t_val   = LD_RP;
            state_n = S_REF;
          end else begin
            state_n = S_ERROR;
            err_n   = (cmd == CMD_PALL) ? ERR_ADDR : ERR_ORDER;
          end
        end
      end

      S_REF: begin
        if (!cmd_nop) begin
          if (!t_zero) begin
            state_n = S_ERROR;
            err_n   = ERR_TIMING;
          end else begin
            case (cmd)
              CMD_AREF: begin
                if (ref_q != 4'hF) ref_n = ref_q + 1'b1;
                t_load = 1'b1;
                t_val  = LD_RFC;
              end
              CMD_PALL: begin
                t_load = 1'b1;
                t_val  = LD_RP;
              end
              CMD_MRS: begin
                if (ref_q < REF_REQ_L) begin
                  state_n = S_ERROR;
                  err_n   = ERR_ORDER;
                end else begin
                  // Fields are latched even when rejected, for debug.
                  bl_n   = addr[2:0];
                  bt_n   = addr[3];
                  cl_n   = addr[6:4];
                  t_load = 1'b1;
                  t_val  = LD_MRD;
                  if (mode_ok(addr[2:0], addr[6:4])) begin
                    state_n = S_MRD;
                  end else begin
                    state_n = S_ERROR;
                    err_n   = ERR_MODE;
                  end
                end
              end
              CMD_ACT, CMD_RD, CMD_WR, CMD_BST: begin
                state_n = S_ERROR;
                err_n   = ERR_ORDER;
              end
              default: begin
                state_n = S_ERROR;
                err_n   = ERR_ORDER;
              end
            endcase
          end
        end
      end

      S_MRD: begin
        if (t_zero) begin
          state_n = S_READY;
        end else if (!cmd_nop) begin
          state_n = S_ERROR;
          err_n   = ERR_TIMING;
        end
      end

      default: ;
    endcase
  end

  assign init_ok  = (state == S_READY);
  assign init_err = (state == S_ERROR);
  assign err_code = err_q;
  assign ref_cnt  = ref_q;
  assign mode_bl  = bl_q;
  assign mode_bt  = bt_q;
  assign mode_cl  = cl_q;

endmodule
